// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Contents: loader state encoding (3 bits) and the instruction word size in bytes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-memory write port of the loader.
// Signals: in_byte/in_valid/in_ready (stream handshake),
//          wr_en/wr_addr/wr_data (memory write side).
// slave  : the loader (consumes the stream, drives the memory write).
// master : the environment (drives the stream, observes the writes).
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_byte, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs stream bytes MSB-first into a 32-bit instruction word and keeps the
// running XOR checksum of every data byte of the current image.
// Ports:
//   clk, clr      clock and synchronous active-high reset
//   load_clr_i    clears word, byte index and checksum for a new image
//   byte_en_i     a data byte is accepted this cycle
//   byte_i        the data byte
//   word_o        assembled word (valid once four bytes are in)
//   csum_o        XOR of all data bytes since load_clr_i
//   word_full_o   the byte accepted this cycle completes a word
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        load_clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o,
  output logic        word_full_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic [7:0]  csum_q;

  // The 2-bit index wraps to zero after the last byte, ready for the next word.
  always_ff @(posedge clk) begin
    if (clr || load_clr_i) begin
      word_q <= '0;
      idx_q  <= '0;
      csum_q <= '0;
    end else if (byte_en_i) begin
      word_q <= {word_q[23:0], byte_i};
      idx_q  <= idx_q + 2'd1;
      csum_q <= csum_q ^ byte_i;
    end
  end

  assign word_full_o = byte_en_i && (idx_q == 2'(WORD_BYTES - 1));
  assign word_o      = word_q;
  assign csum_o      = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into instruction memory while
// holding the CPU stalled. Image: 16-bit big-endian word count N, N 32-bit
// big-endian words, then a 1-byte XOR checksum over all data bytes.
// Ports:
//   clk, clr       clock and synchronous active-high reset (aborts any load)
//   start          one-cycle pulse, honoured in IDLE and ERR
//   bus (slave)    stream in_byte/in_valid/in_ready, memory wr_en/wr_addr/wr_data
//   cpu_hold       CPU stall while a load is in progress or failed
//   done           one-cycle pulse after a load with a good checksum
//   err            sticky error (oversize N or checksum mismatch)
//   words_loaded   words written in the current load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       DEPTH_WORDS = 256
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [15:0]   words_loaded
);

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [15:0] wl_q;
  logic [15:0] len_full;
  logic        accept;
  logic        load_clr;
  logic        byte_en;
  logic [31:0] word;
  logic [7:0]  csum;
  logic        word_full;

  assign accept   = bus.in_valid && bus.in_ready;
  assign byte_en  = accept && (state_q == DATA);
  // Full count as it will be once the low byte in LEN_LO is taken.
  assign len_full = {cnt_q[15:8], bus.in_byte};

  imem_loader_byte_assembler u_asm (
    .clk        (clk),
    .clr        (clr),
    .load_clr_i (load_clr),
    .byte_en_i  (byte_en),
    .byte_i     (bus.in_byte),
    .word_o     (word),
    .csum_o     (csum),
    .word_full_o(word_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LEN_HI;
      LEN_HI:  if (accept) state_d = LEN_LO;
      LEN_LO:
        if (accept) begin
          if (32'(len_full) > DEPTH_WORDS) state_d = ERR;
          else if (len_full == 16'd0)      state_d = CSUM;
          else                             state_d = DATA;
        end
      DATA:    if (word_full) state_d = WRITE;
      WRITE:   state_d = (wl_q + 16'd1 == cnt_q) ? CSUM : DATA;
      CSUM:    if (accept) state_d = (bus.in_byte == csum) ? DONE : ERR;
      DONE:    state_d = IDLE;
      ERR:     if (start) state_d = LEN_HI;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    bus.in_ready = 1'b0;
    bus.wr_en    = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    cpu_hold     = 1'b1;
    load_clr     = 1'b0;
    unique case (state_q)
      IDLE:    cpu_hold = 1'b0;
      LEN_HI:  bus.in_ready = 1'b1;
      LEN_LO: begin
        bus.in_ready = 1'b1;
        load_clr     = 1'b1;
      end
      DATA:    bus.in_ready = 1'b1;
      WRITE:   bus.wr_en = 1'b1;
      CSUM:    bus.in_ready = 1'b1;
      DONE:    done = 1'b1;
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  // Word count and words-written counter
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
      wl_q  <= '0;
    end else begin
      if (start && (state_q == IDLE || state_q == ERR)) wl_q <= '0;
      if (accept && state_q == LEN_HI) cnt_q[15:8] <= bus.in_byte;
      if (accept && state_q == LEN_LO) cnt_q[7:0]  <= bus.in_byte;
      if (state_q == WRITE) wl_q <= wl_q + 16'd1;
    end
  end

  assign bus.wr_addr  = BASE_ADDR + ADDR_W'(wl_q) * ADDR_W'(WORD_BYTES);
  assign bus.wr_data  = bus.wr_en ? word : '0;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int unsigned DEPTH  = 256;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        cpu_hold, done, err;
  logic [15:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .bus         (bus),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: tracks the load in terms of byte position in the image.
  bit          m_loading = 0, m_err = 0, m_hold = 0, m_write_now = 0, m_done_now = 0;
  int unsigned m_idx = 0, m_n = 0, m_wl = 0;
  logic [7:0]  m_xor = '0;
  logic [31:0] m_word = '0, m_wr_addr = '0, m_wr_data = '0;

  logic [63:0] wlog[$];
  int          done_cnt = 0;
  int          rdy_in_wr = 0;

  always @(negedge clk) begin : compare
    bit exp_ready, acc, w, d;
    logic [7:0] b;
    exp_ready = m_loading && !m_write_now;
    chk("in_ready", bus.in_ready, exp_ready);
    chk("wr_en", bus.wr_en, m_write_now);
    if (m_write_now) begin
      chk("wr_addr", bus.wr_addr, m_wr_addr);
      chk("wr_data", bus.wr_data, m_wr_data);
    end
    chk("wr_addr_align", bus.wr_addr[1:0], 2'b00);
    chk("done", done, m_done_now);
    chk("err", err, m_err);
    chk("cpu_hold", cpu_hold, m_hold);
    chk("words_loaded", words_loaded, m_wl);

    if (bus.wr_en === 1'b1) wlog.push_back({bus.wr_addr, bus.wr_data});
    if (done === 1'b1) done_cnt++;
    if (bus.wr_en === 1'b1 && bus.in_ready === 1'b1) rdy_in_wr++;

    if (clr) begin
      m_loading = 0; m_err = 0; m_hold = 0; m_write_now = 0; m_done_now = 0;
      m_idx = 0; m_wl = 0;
    end else begin
      w = m_write_now;
      d = m_done_now;
      acc = exp_ready && bus.in_valid;
      b = bus.in_byte;
      if (w) m_wl++;
      if (d) m_hold = 0;
      m_write_now = 0;
      m_done_now  = 0;
      if (start && !m_loading && !d) begin
        m_loading = 1; m_err = 0; m_wl = 0; m_hold = 1;
        m_idx = 0; m_xor = '0; m_word = '0;
      end else if (acc) begin
        if (m_idx == 0) m_n = 32'(b) << 8;
        else if (m_idx == 1) begin
          m_n = m_n | 32'(b);
          if (m_n > DEPTH) begin m_loading = 0; m_err = 1; end
        end else if (m_idx < 2 + 4 * m_n) begin
          m_xor  = m_xor ^ b;
          m_word = {m_word[23:0], b};
          if ((m_idx - 2) % 4 == 3) begin
            m_write_now = 1;
            m_wr_addr   = BASE + 32'(4 * ((m_idx - 2) / 4));
            m_wr_data   = m_word;
          end
        end else begin
          m_loading = 0;
          if (b == m_xor) m_done_now = 1;
          else m_err = 1;
        end
        m_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_logs();
    wlog.delete();
    done_cnt  = 0;
    rdy_in_wr = 0;
  endtask

  task automatic send(input bq_t b, input int abort_at, input int gap_at,
                      input int gap_len, input bit rnd);
    for (int i = 0; i < b.size(); i++) begin
      int waitc;
      bit acc;
      if (i == abort_at) begin
        bus.in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        return;
      end
      if (i == gap_at) repeat (gap_len) begin bus.in_valid = 1'b0; tick(); end
      if (rnd && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin bus.in_valid = 1'b0; tick(); end
      bus.in_valid = 1'b1;
      bus.in_byte  = b[i];
      if (rnd && $urandom_range(0, 15) == 0) start = 1'b1;
      waitc = 0;
      acc   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = (bus.in_ready === 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!acc) begin
          waitc++;
          if (waitc > 30) begin
            n_checks++;
            $display("FAIL byte_accept_timeout: byte %0d not accepted, waited %0d cycles, limit 30", i, waitc);
            bus.in_valid = 1'b0;
            return;
          end
        end
      end
      bus.in_valid = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t img;
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;

    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    chk("rst_cpu_hold", cpu_hold, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_words_loaded", words_loaded, 16'd0);

    // Single word
    clear_logs();
    do_start();
    chk("t1_hold_high", cpu_hold, 1'b1);
    img = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    send(img, -1, -1, 0, 0);
    repeat (4) tick();
    chk("t1_nwrites", wlog.size(), 1);
    if (wlog.size() > 0) chk("t1_write0", wlog[0], {32'h0, 32'h20080005});
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_hold_low", cpu_hold, 1'b0);
    chk("t1_err", err, 1'b0);
    chk("t1_words_loaded", words_loaded, 16'd1);

    // Two words, in_valid gap mid-word
    clear_logs();
    do_start();
    img = {8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08, 8'h2F};
    send(img, -1, 4, 3, 0);
    repeat (4) tick();
    chk("t2_nwrites", wlog.size(), 2);
    if (wlog.size() > 1) begin
      chk("t2_write0", wlog[0], {32'h0, 32'h8C010004});
      chk("t2_write1", wlog[1], {32'h4, 32'hAC020008});
    end
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_ready_in_write", rdy_in_wr, 0);

    // Bad checksum
    clear_logs();
    do_start();
    img = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    send(img, -1, -1, 0, 0);
    repeat (4) tick();
    chk("t3_nwrites", wlog.size(), 1);
    if (wlog.size() > 0) chk("t3_write0", wlog[0], {32'h0, 32'h20080005});
    chk("t3_err", err, 1'b1);
    chk("t3_done_cnt", done_cnt, 0);
    chk("t3_hold", cpu_hold, 1'b1);
    chk("t3_in_ready", bus.in_ready, 1'b0);

    // Oversize count, restarted from ERR
    clear_logs();
    do_start();
    chk("t4_err_cleared", err, 1'b0);
    img = {8'h01, 8'h01};
    send(img, -1, -1, 0, 0);
    chk("t4_err_now", err, 1'b1);
    repeat (3) tick();
    chk("t4_nwrites", wlog.size(), 0);
    chk("t4_err", err, 1'b1);
    chk("t4_done_cnt", done_cnt, 0);

    // Zero count, then clr mid-DATA, then normal reload
    clear_logs();
    do_start();
    img = {8'h00, 8'h00, 8'h00};
    send(img, -1, -1, 0, 0);
    repeat (3) tick();
    chk("t5_nwrites", wlog.size(), 0);
    chk("t5_done_cnt", done_cnt, 1);
    do_start();
    img = {8'h00, 8'h03, 8'h11, 8'h22};
    send(img, -1, -1, 0, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_in_ready", bus.in_ready, 1'b0);
    chk("t5_clr_wr_en", bus.wr_en, 1'b0);
    chk("t5_clr_wr_addr", bus.wr_addr, 32'h0);
    chk("t5_clr_wr_data", bus.wr_data, 32'h0);
    chk("t5_clr_hold", cpu_hold, 1'b0);
    chk("t5_clr_done", done, 1'b0);
    chk("t5_clr_err", err, 1'b0);
    chk("t5_clr_words", words_loaded, 16'd0);
    clear_logs();
    do_start();
    img = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    send(img, -1, -1, 0, 0);
    repeat (4) tick();
    chk("t5_reload_nwrites", wlog.size(), 1);
    if (wlog.size() > 0) chk("t5_reload_write0", wlog[0], {32'h0, 32'h20080005});
    chk("t5_reload_done", done_cnt, 1);

    // Randomized images
    for (int it = 0; it < 40; it++) begin
      int unsigned n, r;
      logic [7:0]  x, bt;
      bit          good, over;
      int          abort_at;
      r = $urandom_range(0, 19);
      if (it == 0)      n = DEPTH;
      else if (r == 0)  n = 257 + $urandom_range(0, 1000);
      else              n = $urandom_range(0, 8);
      over = (n > DEPTH);
      img = {};
      img.push_back(n[15:8]);
      img.push_back(n[7:0]);
      x = '0;
      if (!over) begin
        for (int k = 0; k < int'(4 * n); k++) begin
          bt = 8'($urandom);
          x = x ^ bt;
          img.push_back(bt);
        end
        good = ($urandom_range(0, 4) != 0);
        img.push_back(good ? x : (x ^ (8'h01 << $urandom_range(0, 7))));
      end else begin
        good = 0;
      end
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, img.size() - 1)) : -1;
      clear_logs();
      do_start();
      send(img, abort_at, -1, 0, 1);
      repeat (3) tick();
      if (abort_at < 0) begin
        chk("rnd_nwrites", wlog.size(), over ? 0 : n);
        chk("rnd_done_cnt", done_cnt, good ? 1 : 0);
        chk("rnd_err", err, good ? 1'b0 : 1'b1);
      end
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writes a program image into instruction memory over a byte-stream valid/ready interface, before the CPU runs.
- It is the write side of the instruction-memory port that the CPU's PC/fetch path only reads.
- While loading, it holds the CPU stopped. When a good image is in place, it pulses done and releases the hold.
- Image format: 16-bit word count N (big-endian), then N 32-bit big-endian instruction words, then a 1-byte XOR checksum over all data bytes.

Parameters:
- BASE_ADDR, 0, byte address of the first word written; must be word-aligned.
- DEPTH_WORDS, 256, instruction memory capacity in words; a larger N is an error.
- ADDR_W, 32, width of wr_addr. Matches the 32-bit PC address.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; starts a load when in IDLE, ignored otherwise.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  byte address of the write, word-aligned.
- wr_data  out  32  instruction word.
- cpu_hold  out  1  keeps the PC/CPU stalled while high.
- done  out  1  one-cycle pulse when a load completes with a good checksum.
- err  out  1  sticky error flag (oversize N or checksum mismatch); cleared by clr or the next start.
- words_loaded  out  16  count of words written in the current load.

Behaviour:
- Reset (clr=1 at a rising edge):
  - State goes to IDLE.
  - in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=0, done=0, err=0, words_loaded=0.
  - clr during any state aborts the load immediately. Partially written words stay in memory.
- Byte acceptance: a byte is taken on a rising edge where in_valid=1 and in_ready=1. in_ready is registered and depends only on state.
- States:
  - IDLE: in_ready=0. On start, clear err and words_loaded, set cpu_hold=1, go to LEN_HI.
  - LEN_HI: in_ready=1. Accepted byte becomes cnt[15:8]; go to LEN_LO.
  - LEN_LO: in_ready=1. Accepted byte becomes cnt[7:0]. Then check the full count:
    - N > DEPTH_WORDS: go to ERR.
    - N == 0: go to CSUM. Expected checksum is 0x00.
    - otherwise: go to DATA with byte index 0 and csum=0.
  - DATA: in_ready=1.
    - Each accepted byte shifts into the word shift register, MSB first, and is XORed into csum.
    - On the 4th byte, go to WRITE.
  - WRITE: in_ready=0 for exactly 1 cycle.
    - wr_en=1; wr_data is the assembled word; wr_addr = BASE_ADDR + 4*words_loaded.
    - Next cycle: words_loaded++. If words_loaded == N, go to CSUM; else go to DATA.
    - Latency: wr_en rises 1 cycle after the 4th byte is accepted.
  - CSUM: in_ready=1. On the accepted byte:
    - equal to csum: go to DONE.
    - otherwise: go to ERR.
  - DONE: 1 cycle. done=1, cpu_hold falls to 0 on the next edge, then go to IDLE.
  - ERR: in_ready=0, err=1, cpu_hold stays 1, no further writes. Leave only via clr or start (start re-enters LEN_HI).
- Sustained throughput: 5 cycles per word (4 byte cycles + 1 WRITE).
- Arithmetic:
  - wr_addr is computed with ADDR_W-bit addition.
  - words_loaded never exceeds DEPTH_WORDS, so the address never wraps past the image.
  - wr_addr[1:0] is always 0.
- Boundary cases:
  - in_valid low inside a word: the partial word and byte index are held indefinitely.
  - start while not IDLE/ERR: ignored.
  - wr_en is never asserted outside WRITE.

Decomposition:
- Shared package (cpu_defs) holds:
  - the state encoding constants IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR (3 bits);
  - the word-size constant 4.
- One natural sub-module: byte_assembler. It holds the 4-byte shift register, the 2-bit byte index, and the running XOR. It has a load-clear input and a word_full output.

Test Plan:
- Single word: start, then bytes 00 01 20 08 00 05 2D.
  - Required: exactly one wr_en with wr_addr=0x0, wr_data=0x20080005.
  - done pulses once, cpu_hold goes 1 then 0, err=0, words_loaded=1.
- Two words with in_valid gaps: bytes 00 02 8C 01 00 04 AC 02 00 08 2F, in_valid dropped for 3 cycles mid-word.
  - Required writes: (0x0, 0x8C010004) and (0x4, 0xAC020008). done=1.
  - Also check: in_ready=0 in each WRITE cycle.
- Bad checksum: same stream as the single-word case but the last byte is 2C.
  - Required: the word is still written, then err=1, no done, cpu_hold stays 1, in_ready=0.
- Oversize: DEPTH_WORDS=256, bytes 01 01.
  - Required: ERR right after LEN_LO, zero wr_en pulses, err=1.
- Zero count and recovery: bytes 00 00 00.
  - Required: done with no writes.
  - Then clr asserted mid-DATA in a second load: all outputs return to reset values on the next edge.
  - A subsequent start with a good image loads normally from BASE_ADDR.
